bus_nibble_receiver: RTL and testbench
======================================

BUS_NIBBLE_RECEIVER -- requirements
Module: bus_nibble_receiver

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of byte entries in the output FIFO; legal values 2, 4, 8.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port BusIn, input, 4 bits: the shared nibble bus, driven by a tri-state bus driver.
REQ-005 SHALL have port load, input, 1 bit: the driver's enable; BusIn is valid and sampled in cycles where load=1.
REQ-006 SHALL have port flush, input, 1 bit: synchronous clear of the partial nibble and the FIFO.
REQ-007 SHALL have port ByteOut, output, 8 bits: the FIFO head byte.
REQ-008 SHALL have port out_valid, output, 1 bit: ByteOut holds a valid byte.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts ByteOut.
REQ-010 SHALL have port full, output, 1 bit: the FIFO holds DEPTH entries.
REQ-011 SHALL have port nib_pending, output, 1 bit: the FSM is in WAIT_HI.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag; a byte was dropped.

Function
REQ-013 SHALL use a 2-state FSM: WAIT_LO and WAIT_HI.
REQ-014 WAIT_LO with load=1 SHALL capture BusIn as the low nibble and move to WAIT_HI.
REQ-015 WAIT_HI with load=1 SHALL form the byte {BusIn, low nibble}, push it to the FIFO, and move to WAIT_LO.
REQ-016 With load=0, the FSM SHALL hold its state and the captured nibble.
REQ-017 The assembled byte SHALL appear at ByteOut with out_valid=1 in the cycle after the high-nibble load, if the FIFO was empty; this is 1-cycle latency.
REQ-018 ByteOut SHALL always show the oldest entry; out_valid SHALL equal not-empty.
REQ-019 A pop SHALL occur when out_valid=1 and out_ready=1; the next entry, if any, appears the following cycle.
REQ-020 ByteOut SHALL be held stable while out_valid=1 and out_ready=0.
REQ-021 A push with the FIFO full and no pop in the same cycle SHALL drop the byte, set overflow=1, and still return the FSM to WAIT_LO.
REQ-022 A push and a pop in the same cycle SHALL both take effect, including when the FIFO is full; the count is unchanged and overflow is not set.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; the count SHALL range 0..DEPTH.
REQ-024 ByteOut SHALL be undefined-but-stable when out_valid=0.
REQ-025 flush=1 SHALL empty the FIFO, clear overflow, and return to WAIT_LO; flush SHALL take priority over load and pop in the same cycle.
REQ-026 overflow SHALL be cleared only by reset or flush.

Reset
REQ-027 reset_n=0 at a clock edge SHALL set: FSM=WAIT_LO, FIFO empty, out_valid=0, full=0, nib_pending=0, overflow=0, ByteOut=8'h00, stored nibble=4'h0.
REQ-028 Reset SHALL override flush, load and out_ready.
REQ-029 A reset asserted mid-byte, in WAIT_HI, SHALL discard the pending low nibble.

Configuration
REQ-030 Macro NIBBLE_TIMEOUT_EN: when defined, a 4-bit counter SHALL count cycles spent in WAIT_HI with load=0.
REQ-031 On reaching 15, the block SHALL discard the low nibble, return to WAIT_LO, and pulse output timeout high for 1 cycle.
REQ-032 The counter SHALL clear on any load, flush or reset.
REQ-033 When NIBBLE_TIMEOUT_EN is undefined, the timeout port and the counter SHALL be absent, and WAIT_HI SHALL persist indefinitely.

Verification
REQ-034 Scenario 1: load with BusIn=4'h5, then load with 4'hA, out_ready=0 -> next cycle out_valid=1, ByteOut=8'hA5; held until out_ready=1.
REQ-035 Scenario 2: with DEPTH=4, push 5 bytes 8'h10..8'h14 with no pops -> full=1 after the 4th, overflow=1 after the 5th; pops return 10,11,12,13.
REQ-036 Scenario 3: FIFO full, push and pop in the same cycle -> count stays 4, overflow=0, the new byte is the last one popped.
REQ-037 Scenario 4: low nibble 4'h3 loaded, then reset_n=0 for 1 cycle, then loads 4'h7 and 4'h8 -> the single byte output is 8'h87.
REQ-038 Scenario 5: load, flush and out_ready all high in the same cycle with 2 entries stored -> FIFO empty, out_valid=0, overflow=0, nib_pending=0.
REQ-039 Scenario 6 (NIBBLE_TIMEOUT_EN): low nibble loaded, then 15 idle cycles -> timeout pulses, nib_pending=0, and the next two loads 4'h1 and 4'h2 give 8'h21.

Source files
------------

// File: rtl/bus_nibble_receiver.sv
// Nibble-to-byte assembler feeding a DEPTH-entry FIFO; byte visible 1 cycle after high-nibble load, popped on out_valid&out_ready.
// Full FIFO with no pop drops the byte (sticky overflow). Optional WAIT_HI timeout via NIBBLE_TIMEOUT_EN.

module bnr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_dat,
  output logic [W-1:0] o_dat,
  output logic         o_empty,
  output logic         o_full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_wr;
  logic          w_rd;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign o_dat   = r_mem[r_rd_ptr];
  assign w_rd    = i_pop && !o_empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_wr    = i_push && (!o_full || w_rd);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mem    <= '{default: '0};
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_dat;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_wr && !w_rd) begin
        r_count <= r_count + 1'b1;
      end else if (w_rd && !w_wr) begin
        r_count <= r_count - 1'b1;
      end
    end
  end
endmodule

module bus_nibble_receiver #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] BusIn,
  input  logic       load,
  input  logic       flush,
  output logic [7:0] ByteOut,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       full,
  output logic       nib_pending,
  output logic       overflow
`ifdef NIBBLE_TIMEOUT_EN
  ,
  output logic       timeout
`endif
);
  typedef enum logic {
    WAIT_LO = 1'b0,
    WAIT_HI = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_nib;
  logic [3:0] w_nib_nxt;
  logic       w_push;
  logic       w_pop;
  logic       w_empty;
  logic       r_overflow;

`ifdef NIBBLE_TIMEOUT_EN
  logic [3:0] r_to_cnt;
  logic       r_timeout;
  logic       w_to_hit;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= WAIT_LO;
      r_nib   <= 4'h0;
    end else begin
      r_state <= w_state_nxt;
      r_nib   <= w_nib_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_nib_nxt   = r_nib;
    w_push      = 1'b0;
`ifdef NIBBLE_TIMEOUT_EN
    w_to_hit    = 1'b0;
`endif
    if (flush) begin
      w_state_nxt = WAIT_LO;
      w_nib_nxt   = 4'h0;
    end else begin
      case (r_state)
        WAIT_LO: begin
          if (load) begin
            w_nib_nxt   = BusIn;
            w_state_nxt = WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (load) begin
            w_push      = 1'b1;
            w_state_nxt = WAIT_LO;
          end
`ifdef NIBBLE_TIMEOUT_EN
          // Fifteenth consecutive idle cycle abandons the half-built byte.
          else if (r_to_cnt == 4'd14) begin
            w_to_hit    = 1'b1;
            w_nib_nxt   = 4'h0;
            w_state_nxt = WAIT_LO;
          end
`endif
        end
        default: w_state_nxt = WAIT_LO;
      endcase
    end
  end

  assign w_pop = out_valid && out_ready && !flush;

  bnr_fifo #(
    .DEPTH (DEPTH),
    .W     (8)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_dat   ({BusIn, r_nib}),
    .o_dat   (ByteOut),
    .o_empty (w_empty),
    .o_full  (full)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_overflow <= 1'b0;
    end else if (w_push && full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

`ifdef NIBBLE_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_to_cnt  <= 4'h0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_to_hit;
      if (flush || load || (r_state == WAIT_LO) || w_to_hit) begin
        r_to_cnt <= 4'h0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  assign timeout = r_timeout;
`endif

  assign out_valid   = !w_empty;
  assign nib_pending = (r_state == WAIT_HI);
  assign overflow    = r_overflow;
endmodule

// File: tb/tb_bus_nibble_receiver.sv
// Directed scenarios plus randomized traffic against a queue-based reference model of bus_nibble_receiver.
// Timeout scenario is compiled in only when NIBBLE_TIMEOUT_EN is defined.

module tb_bus_nibble_receiver;
  localparam int DEPTH = 4;

  logic       clk;
  logic       reset_n;
  logic [3:0] BusIn;
  logic       load;
  logic       flush;
  logic [7:0] ByteOut;
  logic       out_valid;
  logic       out_ready;
  logic       full;
  logic       nib_pending;
  logic       overflow;
`ifdef NIBBLE_TIMEOUT_EN
  logic       timeout;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [7:0] q[$];
  bit         m_pend;
  logic [3:0] m_lo;
  bit         m_ovf;
  int         m_idle;
  bit         m_to;

  bus_nibble_receiver #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .BusIn       (BusIn),
    .load        (load),
    .flush       (flush),
    .ByteOut     (ByteOut),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .full        (full),
    .nib_pending (nib_pending),
    .overflow    (overflow)
`ifdef NIBBLE_TIMEOUT_EN
    ,
    .timeout     (timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic ld, input logic [3:0] bus, input logic fl,
                              input logic rdy, input logic rst_n);
    bit was_full;
    bit popped;
    m_to = 1'b0;
    if (!rst_n) begin
      q.delete(); m_pend = 0; m_lo = 4'h0; m_ovf = 0; m_idle = 0;
    end else if (fl) begin
      q.delete(); m_pend = 0; m_ovf = 0; m_idle = 0;
    end else begin
      was_full = (q.size() == DEPTH);
      popped   = rdy && (q.size() > 0);
      if (popped) void'(q.pop_front());
      if (ld && m_pend) begin
        m_pend = 0;
        m_idle = 0;
        if (was_full && !popped) m_ovf = 1;
        else q.push_back({bus, m_lo});
      end else if (ld) begin
        m_lo   = bus;
        m_pend = 1;
        m_idle = 0;
      end
`ifdef NIBBLE_TIMEOUT_EN
      else if (m_pend) begin
        m_idle++;
        if (m_idle == 15) begin
          m_pend = 0;
          m_idle = 0;
          m_to   = 1;
        end
      end
`endif
    end
  endtask

  task automatic check_all();
    chk("out_valid", out_valid, (q.size() != 0));
    if (q.size() > 0) chk("ByteOut", ByteOut, q[0]);
    chk("full", full, (q.size() == DEPTH));
    chk("nib_pending", nib_pending, m_pend);
    chk("overflow", overflow, m_ovf);
`ifdef NIBBLE_TIMEOUT_EN
    chk("timeout", timeout, m_to);
`endif
  endtask

  task automatic step(input logic ld, input logic [3:0] bus, input logic fl,
                      input logic rdy, input logic rst_n);
    load = ld; BusIn = bus; flush = fl; out_ready = rdy; reset_n = rst_n;
    @(posedge clk);
    model_update(ld, bus, fl, rdy, rst_n);
    #1;
    check_all();
  endtask

  task automatic push_byte(input logic [7:0] b, input logic rdy_on_hi);
    step(1'b1, b[3:0], 1'b0, 1'b0, 1'b1);
    step(1'b1, b[7:4], 1'b0, rdy_on_hi, 1'b1);
  endtask

  initial begin
    logic [7:0] b;
    load = 0; BusIn = 0; flush = 0; out_ready = 0; reset_n = 0;

    // Reset state, with flush/load/ready asserted to show reset overrides them
    step(1'b1, 4'hF, 1'b1, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("rst_ByteOut", ByteOut, 8'h00);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_nib_pending", nib_pending, 1'b0);

    // Scenario 1: 5 then A -> A5, held while out_ready=0
    step(1'b1, 4'h5, 1'b0, 1'b0, 1'b1);
    chk("s1_pending", nib_pending, 1'b1);
    step(1'b1, 4'hA, 1'b0, 1'b0, 1'b1);
    chk("s1_valid", out_valid, 1'b1);
    chk("s1_byte", ByteOut, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
      chk("s1_hold", ByteOut, 8'hA5);
    end
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
    chk("s1_popped", out_valid, 1'b0);

    // Scenario 2: 5 pushes into DEPTH=4 with no pops
    for (int i = 0; i < 5; i++) begin
      push_byte(8'(8'h10 + i), 1'b0);
      if (i == 3) chk("s2_full_after4", full, 1'b1);
      if (i == 3) chk("s2_noovf_after4", overflow, 1'b0);
    end
    chk("s2_ovf_after5", overflow, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("s2_pop_data", ByteOut, 32'(8'h10 + i));
      step(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
    end
    chk("s2_drained", out_valid, 1'b0);
    chk("s2_ovf_sticky", overflow, 1'b1);

    // Scenario 3: full FIFO, push and pop in the same cycle
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
    chk("s3_flush_ovf", overflow, 1'b0);
    for (int i = 0; i < 4; i++) push_byte(8'(8'h20 + i), 1'b0);
    chk("s3_full", full, 1'b1);
    push_byte(8'h24, 1'b1);
    chk("s3_still_full", full, 1'b1);
    chk("s3_no_ovf", overflow, 1'b0);
    b = 8'h00;
    for (int i = 0; i < 4; i++) begin
      b = ByteOut;
      step(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
    end
    chk("s3_last_popped", b, 8'h24);
    chk("s3_empty", out_valid, 1'b0);

    // Scenario 4: reset mid-byte discards the pending low nibble
    step(1'b1, 4'h3, 1'b0, 1'b0, 1'b1);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("s4_rst_pending", nib_pending, 1'b0);
    step(1'b1, 4'h7, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'h8, 1'b0, 1'b0, 1'b1);
    chk("s4_byte", ByteOut, 8'h87);
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
    chk("s4_single", out_valid, 1'b0);

    // Scenario 5: flush beats load and pop
    push_byte(8'h31, 1'b0);
    push_byte(8'h42, 1'b0);
    step(1'b1, 4'h9, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'hC, 1'b1, 1'b1, 1'b1);
    chk("s5_valid", out_valid, 1'b0);
    chk("s5_ovf", overflow, 1'b0);
    chk("s5_pending", nib_pending, 1'b0);
    chk("s5_full", full, 1'b0);

`ifdef NIBBLE_TIMEOUT_EN
    // Scenario 6: 15 idle cycles in WAIT_HI time out
    step(1'b1, 4'hE, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("s6_pending_14", nib_pending, 1'b1);
    chk("s6_no_to_14", timeout, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("s6_timeout", timeout, 1'b1);
    chk("s6_pending_cleared", nib_pending, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("s6_pulse_end", timeout, 1'b0);
    step(1'b1, 4'h1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'h2, 1'b0, 1'b0, 1'b1);
    chk("s6_byte", ByteOut, 8'h21);
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
`endif

    // Randomized traffic: slow consumer first (fills/overflows), then fast
    for (int i = 0; i < 600; i++) begin
      step(logic'($urandom_range(0, 2) != 0),
           4'($urandom),
           logic'($urandom_range(0, 40) == 0),
           (i < 300) ? logic'($urandom_range(0, 3) == 0) : logic'($urandom_range(0, 3) != 0),
           logic'($urandom_range(0, 80) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
